// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module : lsu_pkg
// Brief  : LSU shared types and byte-lane / alignment helpers.
// Rev    : 1.0  initial release
// ============================================================================
package lsu_pkg;

  typedef enum logic [1:0] {
    LSU_BYTE = 2'b00,
    LSU_HALF = 2'b01,
    LSU_WORD = 2'b10
  } lsu_size_t;

  // Reserved size 2'b11 behaves as a word access.
  function automatic logic [3:0] lsu_sel(input logic [1:0] size, input logic [1:0] addr);
    case (size)
      LSU_BYTE: return 4'b0001 << addr;
      LSU_HALF: return 4'b0011 << {addr[1], 1'b0};
      default:  return 4'b1111;
    endcase
  endfunction

  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] addr);
    case (size)
      LSU_BYTE: return 1'b0;
      LSU_HALF: return addr[0];
      default:  return addr != 2'b00;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_bus_t.sv
`default_nettype none
// ============================================================================
// Module : wb_bus_t
// Brief  : 32-bit Wishbone bus bundle with master modport.
// Rev    : 1.0  initial release
// ============================================================================
interface wb_bus_t;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_lock;
  logic        wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_ms;
  logic        wb_tgd_ms;
  logic        wb_tgc;
  logic        wb_tga;
  logic [31:0] wb_dat_sm;
  logic        wb_gnt;
  logic        wb_ack;
  logic        wb_err;
  logic        wb_rty;

  modport master (
    output wb_cyc, wb_stb, wb_lock, wb_we, wb_sel, wb_adr,
           wb_dat_ms, wb_tgd_ms, wb_tgc, wb_tga,
    input  wb_dat_sm, wb_gnt, wb_ack, wb_err, wb_rty
  );
endinterface
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module : load_align
// Brief  : Combinational lane extraction and sign/zero extension of a load.
// Rev    : 1.0  initial release
// ============================================================================
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = raw[{addr, 3'b000} +: 8];
  assign half_lane = raw[{addr[1], 4'b0000} +: 16];

  always_comb begin
    result = raw;
    case (size)
      LSU_BYTE: result = {{24{sign_ext & byte_lane[7]}}, byte_lane};
      LSU_HALF: result = {{16{sign_ext & half_lane[15]}}, half_lane};
      default:  result = raw;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_unit.sv
`default_nettype none
// ============================================================================
// Module : load_unit
// Brief  : Wishbone master for single LSU loads; optional misalignment trap
//          enabled by LOAD_UNIT_MISALIGN_CHECK_EN.
// Rev    : 1.0  initial release
// ============================================================================
module load_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn_i,
  input  logic        read_i,
  input  logic [31:0] addr_i,
  input  logic [1:0]  size_i,
  input  logic        sign_ext_i,
  output logic [31:0] data_o,
  output logic        valid_o,
  output logic        err_o,
  wb_bus_t.master     wb_bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    READ = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t      state;
  logic [31:0] aligned;
  logic [3:0]  sel;
  logic        mis_trap;
  logic        strobe;

  assign sel = lsu_sel(size_i, addr_i[1:0]);

`ifdef LOAD_UNIT_MISALIGN_CHECK_EN
  assign mis_trap = lsu_misaligned(size_i, addr_i[1:0]);
`else
  assign mis_trap = 1'b0;
`endif

  load_align u_align (
    .raw      (wb_bus.wb_dat_sm),
    .addr     (addr_i[1:0]),
    .size     (size_i),
    .sign_ext (sign_ext_i),
    .result   (aligned)
  );

  assign strobe = (state == READ) && wb_bus.wb_gnt;

  // The IDLE request term is combinational, so it is also masked by reset.
  assign wb_bus.wb_cyc    = rstn_i && (((state == IDLE) && read_i && !mis_trap) || (state == READ));
  assign wb_bus.wb_lock   = (state == READ);
  assign wb_bus.wb_stb    = strobe;
  assign wb_bus.wb_sel    = strobe ? sel : 4'h0;
  assign wb_bus.wb_adr    = {addr_i[31:2], 2'b00};
  assign wb_bus.wb_we     = 1'b0;
  assign wb_bus.wb_dat_ms = 32'h0;
  assign wb_bus.wb_tgd_ms = 1'b0;
  assign wb_bus.wb_tgc    = 1'b0;
  assign wb_bus.wb_tga    = 1'b0;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state   <= IDLE;
      data_o  <= 32'h0;
      valid_o <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      err_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (read_i) begin
            if (mis_trap) begin
              err_o <= 1'b1;
              state <= RESP;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          // A dropped request abandons the cycle; any later ack is ignored.
          if (!read_i) begin
            state <= IDLE;
          end else if (wb_bus.wb_gnt && wb_bus.wb_ack) begin
            data_o  <= aligned;
            valid_o <= 1'b1;
            state   <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_load_unit
// Brief  : Self-checking bench for load_unit: directed table, corner
//          sequences and randomized loads against a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_load_unit;

`ifdef LOAD_UNIT_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        read;
  logic [31:0] addr;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] data;
  logic        valid;
  logic        err;

  wb_bus_t bus ();

  load_unit dut (
    .clk        (clk),
    .rstn_i     (rstn),
    .read_i     (read),
    .addr_i     (addr),
    .size_i     (size),
    .sign_ext_i (sign_ext),
    .data_o     (data),
    .valid_o    (valid),
    .err_o      (err),
    .wb_bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: which bytes a load covers and what value it yields.
  function automatic int nbytes(input logic [1:0] sz);
    if (sz == 2'd0) return 1;
    if (sz == 2'd1) return 2;
    return 4;
  endfunction

  function automatic int first_lane(input logic [31:0] a, input logic [1:0] sz);
    int n = nbytes(sz);
    return (int'(a % 4) / n) * n;
  endfunction

  function automatic logic [3:0] model_sel(input logic [31:0] a, input logic [1:0] sz);
    logic [3:0] m = 4'h0;
    int lo = first_lane(a, sz);
    for (int k = 0; k < 4; k++)
      if (k >= lo && k < lo + nbytes(sz)) m[k] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] model_data(input logic [31:0] d, input logic [31:0] a,
                                             input logic [1:0] sz, input logic sx);
    int n = nbytes(sz);
    longint v = longint'(d) / (longint'(1) << (8 * first_lane(a, sz)));
    longint span = longint'(1) << (8 * n);
    if (n < 4) begin
      v = v % span;
      if (sx && v >= span / 2) v = v - span;
    end
    return 32'(v);
  endfunction

  function automatic logic model_err(input logic [31:0] a, input logic [1:0] sz);
    return MIS_EN && (a % nbytes(sz) != 0);
  endfunction

  task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic sx,
                         input logic [31:0] dat, input int gd, input int ad,
                         input logic exp_err, input logic [31:0] exp_data,
                         input logic [3:0] exp_sel);
    @(negedge clk);
    read = 1'b1; addr = a; size = sz; sign_ext = sx;
    bus.wb_dat_sm = dat; bus.wb_gnt = 1'b0; bus.wb_ack = 1'b0;
    #1;
    check("cyc_request", bus.wb_cyc, !exp_err);
    check("adr", bus.wb_adr, {a[31:2], 2'b00});
    check("we", bus.wb_we, 1'b0);
    if (exp_err) begin
      @(negedge clk);
      check("err_pulse", err, 1'b1);
      check("valid_on_err", valid, 1'b0);
      check("cyc_on_err", bus.wb_cyc, 1'b0);
      check("data_kept_err", data, last_data);
      read = 1'b0;
      @(negedge clk);
      check("err_single", err, 1'b0);
    end else begin
      for (int k = 0; k <= gd + ad; k++) begin
        @(negedge clk);
        bus.wb_gnt = (k >= gd);
        bus.wb_ack = (k >= gd + ad);
        #1;
        check("valid_wait", valid, 1'b0);
        check("cyc_read", bus.wb_cyc, 1'b1);
        check("lock_read", bus.wb_lock, 1'b1);
        check("stb_gnt", bus.wb_stb, bus.wb_gnt);
        check("sel", bus.wb_sel, bus.wb_gnt ? exp_sel : 4'h0);
      end
      @(negedge clk);
      bus.wb_gnt = 1'b0; bus.wb_ack = 1'b0;
      check("valid_pulse", valid, 1'b1);
      check("data", data, exp_data);
      check("err_none", err, 1'b0);
      check("lock_resp", bus.wb_lock, 1'b0);
      read = 1'b0;
      last_data = exp_data;
      @(negedge clk);
      check("valid_single", valid, 1'b0);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [1:0]  sz;
    logic        sx;
    logic [31:0] dat;
    int          gd;
    int          ad;
    logic [31:0] exp_data;
    logic [3:0]  exp_sel;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h100, 2'd2, 1'b0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 4'hF};
    vecs[1] = '{32'h103, 2'd0, 1'b1, 32'h80000000, 0, 0, 32'hFFFFFF80, 4'b1000};
    vecs[2] = '{32'h103, 2'd0, 1'b0, 32'h80000000, 0, 0, 32'h00000080, 4'b1000};
    vecs[3] = '{32'h202, 2'd1, 1'b1, 32'h7FFF1234, 3, 2, 32'h00007FFF, 4'b1100};
    vecs[4] = '{32'h200, 2'd1, 1'b1, 32'h7FFF8234, 0, 1, 32'hFFFF8234, 4'b0011};
    vecs[5] = '{32'h101, 2'd0, 1'b1, 32'h12345678, 1, 0, 32'h00000056, 4'b0010};
    vecs[6] = '{32'h102, 2'd0, 1'b1, 32'h00F00000, 0, 0, 32'hFFFFFFF0, 4'b0100};
    vecs[7] = '{32'h3FC, 2'd2, 1'b1, 32'h80000001, 2, 0, 32'h80000001, 4'hF};
    vecs[8] = '{32'h010, 2'd3, 1'b1, 32'hCAFEF00D, 0, 0, 32'hCAFEF00D, 4'hF};

    rstn = 1'b0; read = 1'b0; addr = 32'h0; size = 2'd0; sign_ext = 1'b0;
    bus.wb_dat_sm = 32'h0; bus.wb_gnt = 1'b0; bus.wb_ack = 1'b0;
    bus.wb_err = 1'b0; bus.wb_rty = 1'b0;
    last_data = 32'h0;
    #12;
    check("rst_data", data, 32'h0);
    check("rst_valid", valid, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_cyc", bus.wb_cyc, 1'b0);
    check("rst_sel", bus.wb_sel, 4'h0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 9; i++)
      do_load(vecs[i].a, vecs[i].sz, vecs[i].sx, vecs[i].dat, vecs[i].gd, vecs[i].ad,
              1'b0, vecs[i].exp_data, vecs[i].exp_sel);

    // Abort before ack, then a late ack that must be ignored.
    @(negedge clk);
    read = 1'b1; addr = 32'h300; size = 2'd2; sign_ext = 1'b0; bus.wb_dat_sm = 32'h55AA55AA;
    @(negedge clk);
    bus.wb_gnt = 1'b1;
    @(negedge clk);
    read = 1'b0;
    #1 check("abort_cyc_still", bus.wb_cyc, 1'b1);
    @(negedge clk);
    bus.wb_ack = 1'b1;
    #1;
    check("abort_cyc_drop", bus.wb_cyc, 1'b0);
    check("abort_stb_drop", bus.wb_stb, 1'b0);
    check("abort_no_valid", valid, 1'b0);
    @(negedge clk);
    check("abort_late_valid", valid, 1'b0);
    check("abort_data_kept", data, last_data);
    bus.wb_gnt = 1'b0; bus.wb_ack = 1'b0;

    // Asynchronous reset while waiting in READ.
    @(negedge clk);
    read = 1'b1; addr = 32'h40; size = 2'd2;
    @(negedge clk);
    bus.wb_gnt = 1'b1;
    #1 check("pre_rst_cyc", bus.wb_cyc, 1'b1);
    #2 rstn = 1'b0;
    #1;
    check("arst_cyc", bus.wb_cyc, 1'b0);
    check("arst_stb", bus.wb_stb, 1'b0);
    check("arst_lock", bus.wb_lock, 1'b0);
    check("arst_sel", bus.wb_sel, 4'h0);
    check("arst_valid", valid, 1'b0);
    check("arst_data", data, 32'h0);
    read = 1'b0; bus.wb_gnt = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    last_data = 32'h0;
    do_load(vecs[0].a, vecs[0].sz, vecs[0].sx, vecs[0].dat, 0, 0, 1'b0, 32'hDEADBEEF, 4'hF);

    // Misaligned word: trapped when the check is built in, otherwise a plain word load.
    if (MIS_EN) do_load(32'h101, 2'd2, 1'b0, 32'h13579BDF, 0, 0, 1'b1, 32'h0, 4'h0);
    else        do_load(32'h101, 2'd2, 1'b0, 32'h13579BDF, 0, 0, 1'b0, 32'h13579BDF, 4'hF);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a, d;
      logic [1:0]  sz;
      logic        sx;
      a  = $urandom;
      d  = $urandom;
      sz = 2'($urandom_range(0, 3));
      sx = 1'($urandom_range(0, 1));
      do_load(a, sz, sx, d, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              model_err(a, sz), model_data(d, a, sz, sx), model_sel(a, sz));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_unit.md
Name: load_unit

Overview:
- Wishbone master that performs single load (read) transactions for the core's LSU. It is the read-side counterpart of store_unit.
- Accepts a load request of byte, halfword or word size and drives one Wishbone read cycle.
- Captures the returned word, aligns it, and sign- or zero-extends it to 32 bits.
- Returns a one-cycle valid pulse with registered data.

Parameters:
- none (bus width fixed at 32 bits, byte granularity on wb_sel)

Ports:
- clk  in  1  system clock, rising edge
- rstn_i  in  1  asynchronous active-low reset
- read_i  in  1  load request; held high with addr_i/size_i/sign_ext_i stable until valid_o or err_o
- addr_i  in  32  byte address
- size_i  in  2  access size: 2'b00 byte, 2'b01 halfword, 2'b10 word, 2'b11 reserved (treated as word)
- sign_ext_i  in  1  1 = sign-extend, 0 = zero-extend (ignored for word)
- data_o  out  32  loaded, aligned, extended data (registered)
- valid_o  out  1  one-cycle pulse: data_o valid
- err_o  out  1  one-cycle pulse: misaligned access (see Optional Feature)
- wb_bus  wb_bus_t.master  -  Wishbone master port

Behaviour:
- Clock/reset: one clock clk. Reset rstn_i is asynchronous, active-low.
- Reset values: state IDLE, data_o 32'h0, valid_o 0, err_o 0, wb_cyc/wb_stb/wb_lock 0, wb_sel 4'h0.
- Constant bus fields:
  - wb_we=0
  - wb_dat_ms=0, wb_tgd_ms=0, wb_tgc=0, wb_tga=0
  - wb_adr = {addr_i[31:2],2'b00}
- Byte lanes:
  - byte: wb_sel = 4'b0001<<addr_i[1:0]
  - half: wb_sel = 4'b0011<<{addr_i[1],1'b0}
  - word/reserved: wb_sel = 4'b1111
- FSM states IDLE, READ, RESP:
  - IDLE: wb_cyc=1 combinationally when read_i. Next state is READ if read_i, else IDLE.
  - READ: wb_cyc=1 and wb_lock=1.
    - When wb_gnt=1: wb_stb=1 and wb_sel driven.
    - When wb_gnt & wb_ack: capture aligned/extended wb_dat_sm into data_o; next state RESP.
    - Wait states (gnt or ack low) are unbounded; the FSM stays in READ.
  - RESP: valid_o=1 (registered) and bus idle. Next state is always IDLE.
    - If read_i is still high in IDLE, that is a new request; the requester drops read_i the cycle after valid_o.
- Minimum latency: read_i rises in cycle 0 → READ in cycle 1 (gnt and ack same cycle) → valid_o in cycle 2.
- Alignment/extension:
  - Shift wb_dat_sm right by 8*addr_i[1:0] (half uses addr_i[1] only).
  - byte: bits [7:0], extension bit = bit 7 if sign_ext_i.
  - half: bits [15:0], extension bit = bit 15 if sign_ext_i.
  - word: unchanged.
- Abort: read_i dropped while in READ → next state IDLE, wb_cyc/wb_stb drop the next cycle. A late ack is ignored and data_o is not updated.
- data_o holds its last value between loads; it is updated only on a captured ack.
- Reset mid-transaction: immediate return to IDLE, all bus outputs low, no valid_o.
- wb_err/wb_rty are not used.

Optional Feature:
- Macro LOAD_UNIT_MISALIGN_CHECK_EN.
- Defined:
  - In IDLE, read_i with half & addr_i[0]=1, or word & addr_i[1:0]≠0, raises err_o the next cycle (registered, one-cycle pulse).
  - No wb_cyc is raised and data_o is unchanged. The FSM moves IDLE→RESP-equivalent error cycle→IDLE.
- Undefined:
  - err_o tied 0.
  - Low address bits are ignored for lane selection beyond the size: half uses addr_i[1], word uses none.
  - The access proceeds normally.

Decomposition:
- Shared package lsu_pkg:
  - enum lsu_size_t {LSU_BYTE=2'b00, LSU_HALF=2'b01, LSU_WORD=2'b10}
  - function lsu_sel(size, addr[1:0]) returning the 4-bit byte mask, also usable by store_unit
  - function lsu_misaligned(size, addr[1:0])
- Sub-module load_align: purely combinational. Inputs: raw 32-bit word, addr[1:0], size, sign_ext. Output: 32-bit result. Kept separate for unit-level exhaustive testing.

Test Plan:
- Word load, gnt=ack=1 immediately, addr 32'h100, wb_dat_sm 32'hDEADBEEF → wb_sel 4'hF, wb_adr 32'h100, valid_o in cycle 2, data_o 32'hDEADBEEF.
- Signed byte, addr 32'h103, wb_dat_sm 32'h80_00_00_00 → wb_sel 4'b1000, data_o 32'hFFFFFF80. Same access unsigned → data_o 32'h00000080.
- Signed half, addr 32'h202, wb_dat_sm 32'h7FFF_1234, gnt delayed 3 cycles, ack delayed 2 more → wb_stb only while gnt, wb_sel 4'b1100, data_o 32'h00007FFF, single valid_o pulse.
- Abort: read_i dropped in READ before ack, then ack asserted one cycle late → wb_cyc low next cycle, no valid_o, data_o unchanged.
- Reset: rstn_i pulsed low while in READ → all outputs 0 asynchronously; next read_i completes normally.
- With LOAD_UNIT_MISALIGN_CHECK_EN: word load at addr 32'h101 → err_o one-cycle pulse, wb_cyc never asserted, valid_o 0. Without the macro: same access completes with wb_sel 4'hF and valid_o.
